// File: rtl/uart_pkg.sv
// uart_pkg -- constants shared by the UART transmit path.
//   PARITY_*  : parity-mode selectors for the framer PARITY parameter
//   ST_*      : framer state encodings (3-bit, legacy-compatible values)
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_tx_framer_if.sv
// uart_tx_framer_if -- word handshake into the UART transmit framer.
//   data_i  : word to send (WORD_BITS wide)
//   valid_i : data_i is valid
//   ready_o : framer holding register is empty; transfer on valid_i && ready_o
// Modports: master = word producer, slave = framer.
interface uart_tx_framer_if #(
    parameter int WORD_BITS = 8
) ();

    logic [WORD_BITS-1:0] data_i;
    logic                 valid_i;
    logic                 ready_o;

    modport master (output data_i, output valid_i, input ready_o);
    modport slave  (input data_i, input valid_i, output ready_o);

endinterface

// File: rtl/uart_tx_framer.sv
// uart_tx_framer -- serialises words into UART frames:
// start bit, WORD_BITS data bits LSB first, optional parity, 1 or 2 stop bits.
// A one-entry holding register lets the next word queue behind the frame in
// flight, so back-to-back frames leave no idle gap on the line.
//   clk_i     : clock, rising edge
//   reset_i   : asynchronous, active-high reset
//   baud_i    : one-clk oversample tick, SAMPLE_TICKS ticks per bit
//   host      : word handshake (data_i / valid_i / ready_o), slave side
//   tx_o      : serial line, idles high
//   busy_o    : a frame is on the line
//   tx_done_o : one-clk pulse at the end of each frame
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int WORD_BITS    = 8,   // 5..9
    parameter int SAMPLE_TICKS = 16,  // >= 2
    parameter int PARITY       = 0,   // PARITY_NONE / PARITY_EVEN / PARITY_ODD
    parameter int STOP_BITS    = 1    // 1 or 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  baud_i,
    uart_tx_framer_if.slave       host,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  tx_done_o
);

    localparam int TICK_W = $clog2(SAMPLE_TICKS);
    localparam int BIT_W  = $clog2(WORD_BITS);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_TICKS - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WORD_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    logic [2:0]           state;
    logic [WORD_BITS-1:0] shift_q;
    logic [WORD_BITS-1:0] hold_q;
    logic                 hold_full;
    logic                 ready_q;
    logic                 parity_bit;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;

    logic load;
    logic bit_end;
    logic final_stop;
    logic start_frame;

    assign load        = host.valid_i && ready_q;
    assign bit_end     = baud_i && (tick_cnt == TICK_LAST);
    assign final_stop  = bit_end && (state == ST_STOP) && (bit_cnt == STOP_LAST);
    // A queued word starts either from idle or on the last stop tick of the
    // current frame, so consecutive frames abut with no idle bit between them.
    assign start_frame = hold_full && ((state == ST_IDLE) || final_stop);

    assign host.ready_o = ready_q;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= ST_IDLE;
            shift_q    <= '0;
            // NOTE: the holding word is reset with everything else; it is a
            // single register, not a RAM, so the reset costs nothing and keeps
            // post-reset behaviour fully defined.
            hold_q     <= '0;
            hold_full  <= 1'b0;
            ready_q    <= 1'b1;
            parity_bit <= 1'b0;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            tx_o       <= 1'b1;
            busy_o     <= 1'b0;
            tx_done_o  <= 1'b0;
        end else begin
            tx_done_o <= final_stop;

            if (start_frame) begin
                // Parity is taken from the word as loaded; later data_i changes
                // cannot reach the frame because only hold_q feeds it.
                state      <= ST_START;
                shift_q    <= hold_q;
                parity_bit <= (PARITY == PARITY_ODD) ? ~(^hold_q) : ^hold_q;
                tick_cnt   <= '0;
                bit_cnt    <= '0;
                tx_o       <= 1'b0;
                busy_o     <= 1'b1;
            end else if (baud_i && (state != ST_IDLE)) begin
                // Bit timing advances only on baud ticks; with baud_i low the
                // frame is frozen exactly where it is.
                if (!bit_end) begin
                    tick_cnt <= tick_cnt + TICK_W'(1);
                end else begin
                    tick_cnt <= '0;
                    case (state)
                        ST_START: begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                            tx_o    <= shift_q[0];
                        end
                        ST_DATA: begin
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt <= '0;
                                if (PARITY != PARITY_NONE) begin
                                    state <= ST_PARITY;
                                    tx_o  <= parity_bit;
                                end else begin
                                    state <= ST_STOP;
                                    tx_o  <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                                shift_q <= shift_q >> 1;
                                tx_o    <= shift_q[1];
                            end
                        end
                        ST_PARITY: begin
                            state   <= ST_STOP;
                            bit_cnt <= '0;
                            tx_o    <= 1'b1;
                        end
                        ST_STOP: begin
                            // The last stop bit with a queued word is handled by
                            // start_frame above; here the line goes idle.
                            if (bit_cnt == STOP_LAST) begin
                                state   <= ST_IDLE;
                                bit_cnt <= '0;
                                busy_o  <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end
                        default: begin
                            state  <= ST_IDLE;
                            tx_o   <= 1'b1;
                            busy_o <= 1'b0;
                        end
                    endcase
                end
            end

            // Holding register: load and hand-off never coincide, because a
            // load needs ready (empty) and a hand-off needs a full register.
            if (start_frame) begin
                hold_full <= 1'b0;
            end
            if (load) begin
                hold_full <= 1'b1;
                hold_q    <= host.data_i;
            end
            ready_q <= !(load || (hold_full && !start_frame));
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer -- directed checks of uart_tx_framer across four
// parameterisations: default, even parity, odd parity, 7 data + 2 stop bits.
// Expected frames are hand-computed bit strings, index 0 = first bit on the line.
module tb_uart_tx_framer;

    logic clk;
    logic rst;
    logic baud;

    int vectors;
    int miscompares;
    int sel;

    uart_tx_framer_if #(.WORD_BITS(8)) if0 ();
    uart_tx_framer_if #(.WORD_BITS(8)) if1 ();
    uart_tx_framer_if #(.WORD_BITS(8)) if2 ();
    uart_tx_framer_if #(.WORD_BITS(7)) if3 ();

    logic tx0, tx1, tx2, tx3;
    logic busy0, busy1, busy2, busy3;
    logic done0, done1, done2, done3;
    logic cur_tx, cur_busy, cur_done, cur_ready;

    uart_tx_framer u0 (
        .clk_i(clk), .reset_i(rst), .baud_i(baud), .host(if0),
        .tx_o(tx0), .busy_o(busy0), .tx_done_o(done0));

    uart_tx_framer #(.PARITY(1)) u1 (
        .clk_i(clk), .reset_i(rst), .baud_i(baud), .host(if1),
        .tx_o(tx1), .busy_o(busy1), .tx_done_o(done1));

    uart_tx_framer #(.PARITY(2)) u2 (
        .clk_i(clk), .reset_i(rst), .baud_i(baud), .host(if2),
        .tx_o(tx2), .busy_o(busy2), .tx_done_o(done2));

    uart_tx_framer #(.WORD_BITS(7), .STOP_BITS(2)) u3 (
        .clk_i(clk), .reset_i(rst), .baud_i(baud), .host(if3),
        .tx_o(tx3), .busy_o(busy3), .tx_done_o(done3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 500 us");
        $fatal(1);
    end

    always_comb begin
        case (sel)
            0: begin cur_tx = tx0; cur_busy = busy0; cur_done = done0; cur_ready = if0.ready_o; end
            1: begin cur_tx = tx1; cur_busy = busy1; cur_done = done1; cur_ready = if1.ready_o; end
            2: begin cur_tx = tx2; cur_busy = busy2; cur_done = done2; cur_ready = if2.ready_o; end
            default: begin cur_tx = tx3; cur_busy = busy3; cur_done = done3; cur_ready = if3.ready_o; end
        endcase
    end

    task automatic drive(input int s, input logic v, input logic [8:0] d);
        case (s)
            0: begin if0.valid_i = v; if0.data_i = d[7:0]; end
            1: begin if1.valid_i = v; if1.data_i = d[7:0]; end
            2: begin if2.valid_i = v; if2.data_i = d[7:0]; end
            default: begin if3.valid_i = v; if3.data_i = d[6:0]; end
        endcase
    endtask

    // Offer one word at a negedge, hold it for one edge, then scramble data_i.
    task automatic send_word(input int s, input logic [8:0] d);
        int w;
        sel = s;
        w = 0;
        while (cur_ready !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (cur_ready !== 1'b1) begin
            $display("FAIL send_ready: ready_o=%b, required 1 within 400 clks", cur_ready);
            miscompares++;
        end
        drive(s, 1'b1, d);
        @(negedge clk);
        drive(s, 1'b0, ~d);
        vectors++;
        if (cur_ready !== 1'b0) begin
            $display("FAIL send_full: ready_o=%b after transfer, required 0", cur_ready);
            miscompares++;
        end
    endtask

    // Follows one frame sample by sample (16 clks per bit, baud_i high).
    // On return the current negedge is the one right after the final stop tick.
    task automatic run_frame(input int s, input logic [15:0] bits, input int nbits,
                             input bit offer_en, input logic [8:0] offer_data,
                             input int freeze_at, input string name);
        int w;
        int done_cnt;
        int bad;
        sel = s;
        w = 0;
        while (cur_tx !== 1'b0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (cur_tx !== 1'b0) begin
            $display("FAIL %s_start: tx_o=%b, required 0 within 40 clks", name, cur_tx);
            miscompares++;
            return;
        end
        done_cnt = 0;
        for (int n = 0; n <= nbits * 16; n++) begin
            if (n == nbits * 16) begin
                vectors++;
                if (cur_done !== 1'b1) begin
                    $display("FAIL %s_done: tx_done_o=%b at clk %0d, required 1", name, cur_done, n);
                    miscompares++;
                end
                vectors++;
                if (cur_tx !== !offer_en) begin
                    $display("FAIL %s_end_tx: tx_o=%b at clk %0d, required %b", name, cur_tx, n, !offer_en);
                    miscompares++;
                end
                vectors++;
                if (cur_busy !== offer_en) begin
                    $display("FAIL %s_end_busy: busy_o=%b, required %b", name, cur_busy, offer_en);
                    miscompares++;
                end
            end else begin
                if (n % 16 == 0 || n % 16 == 15) begin
                    vectors++;
                    if (cur_tx !== bits[n / 16]) begin
                        $display("FAIL %s_bit%0d: tx_o=%b at clk %0d, required %b",
                                 name, n / 16, cur_tx, n, bits[n / 16]);
                        miscompares++;
                    end
                end
                if (n % 16 == 8) begin
                    vectors++;
                    if (cur_busy !== 1'b1) begin
                        $display("FAIL %s_busy: busy_o=%b at clk %0d, required 1", name, cur_busy, n);
                        miscompares++;
                    end
                end
                if (n > 0 && cur_done === 1'b1) done_cnt++;
                if (n == 0) begin
                    vectors++;
                    if (cur_ready !== 1'b1) begin
                        $display("FAIL %s_ready_start: ready_o=%b, required 1", name, cur_ready);
                        miscompares++;
                    end
                    if (offer_en) drive(s, 1'b1, offer_data);
                end
                if (n == 1 && offer_en) drive(s, 1'b0, ~offer_data);
                if (n == 8) begin
                    vectors++;
                    if (cur_ready !== !offer_en) begin
                        $display("FAIL %s_ready_mid: ready_o=%b, required %b", name, cur_ready, !offer_en);
                        miscompares++;
                    end
                end
                if (n == freeze_at) begin
                    baud = 1'b0;
                    bad = 0;
                    repeat (100) begin
                        @(negedge clk);
                        if (cur_tx !== bits[n / 16] || cur_done !== 1'b0 || cur_busy !== 1'b1) bad++;
                    end
                    baud = 1'b1;
                    vectors++;
                    if (bad != 0) begin
                        $display("FAIL %s_freeze: %0d of 100 frozen clks changed, required 0", name, bad);
                        miscompares++;
                    end
                end
                @(negedge clk);
            end
        end
        vectors++;
        if (done_cnt != 0) begin
            $display("FAIL %s_early_done: %0d tx_done_o clks inside frame, required 0", name, done_cnt);
            miscompares++;
        end
        if (!offer_en) begin
            @(negedge clk);
            vectors++;
            if (cur_done !== 1'b0) begin
                $display("FAIL %s_done_width: tx_done_o=%b one clk after pulse, required 0", name, cur_done);
                miscompares++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            vectors++;
            if (cur_tx !== 1'b1 || cur_ready !== 1'b1 || cur_busy !== 1'b0 || cur_done !== 1'b0) begin
                $display("FAIL reset_dut%0d: tx/ready/busy/done=%b%b%b%b, required 1100",
                         s, cur_tx, cur_ready, cur_busy, cur_done);
                miscompares++;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        sel = 0;
        vectors++;
        if (cur_tx !== 1'b1 || cur_ready !== 1'b1 || cur_busy !== 1'b0) begin
            $display("FAIL reset_release: tx/ready/busy=%b%b%b, required 110", cur_tx, cur_ready, cur_busy);
            miscompares++;
        end
    endtask

    // 0x55: 0,1,0,1,0,1,0,1,0,1
    task automatic test_basic();
        send_word(0, 9'h055);
        run_frame(0, 16'h02AA, 10, 1'b0, 9'h000, -1, "basic");
    endtask

    // 0x07 with parity: even -> parity bit 1, odd -> parity bit 0, 11 bits.
    task automatic test_parity();
        send_word(1, 9'h007);
        run_frame(1, 16'h060E, 11, 1'b0, 9'h000, -1, "even");
        send_word(2, 9'h007);
        run_frame(2, 16'h040E, 11, 1'b0, 9'h000, -1, "odd");
    endtask

    // 7 data bits, 2 stop bits, 0x41: 0,1,0,0,0,0,0,1,1,1
    task automatic test_stop2();
        send_word(3, 9'h041);
        run_frame(3, 16'h0382, 10, 1'b0, 9'h000, -1, "stop2");
    endtask

    // 0xA5 then 0x3C queued during the first frame; second start bit at clk 160.
    task automatic test_back_to_back();
        send_word(0, 9'h0A5);
        run_frame(0, 16'h034A, 10, 1'b1, 9'h03C, -1, "b2b_first");
        run_frame(0, 16'h0278, 10, 1'b0, 9'h000, -1, "b2b_second");
    endtask

    // baud_i low for 100 clks in the middle of data bit 1 (frame bit 2).
    task automatic test_baud_freeze();
        send_word(0, 9'h055);
        run_frame(0, 16'h02AA, 10, 1'b0, 9'h000, 40, "freeze");
    endtask

    // Reset during data bit 3 with a second word queued: all discarded.
    task automatic test_reset_midframe();
        int w;
        int lows;
        int dones;
        send_word(0, 9'h055);
        w = 0;
        while (cur_tx !== 1'b0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        for (int n = 0; n < 70; n++) begin
            if (n == 2) drive(0, 1'b1, 9'h03C);
            if (n == 3) drive(0, 1'b0, 9'h000);
            @(negedge clk);
        end
        vectors++;
        if (cur_tx !== 1'b0 || cur_ready !== 1'b0 || cur_busy !== 1'b1) begin
            $display("FAIL rst_mid_pre: tx/ready/busy=%b%b%b, required 001", cur_tx, cur_ready, cur_busy);
            miscompares++;
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (cur_tx !== 1'b1 || cur_ready !== 1'b1 || cur_busy !== 1'b0 || cur_done !== 1'b0) begin
            $display("FAIL rst_mid_async: tx/ready/busy/done=%b%b%b%b, required 1100",
                     cur_tx, cur_ready, cur_busy, cur_done);
            miscompares++;
        end
        @(negedge clk);
        rst = 1'b0;
        lows = 0;
        dones = 0;
        repeat (200) begin
            @(negedge clk);
            if (cur_tx !== 1'b1) lows++;
            if (cur_done !== 1'b0) dones++;
        end
        vectors++;
        if (lows != 0 || dones != 0) begin
            $display("FAIL rst_mid_after: %0d tx_o low clks, %0d tx_done_o clks, required 0 and 0", lows, dones);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        sel         = 0;
        rst         = 1'b1;
        baud        = 1'b1;
        for (int s = 0; s < 4; s++) drive(s, 1'b0, 9'h000);

        test_reset();
        test_basic();
        test_parity();
        test_stop2();
        test_back_to_back();
        test_baud_freeze();
        test_reset_midframe();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter WORD_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter SAMPLE_TICKS, default 16, baud ticks per bit period, legal >= 2.
REQ-003 SHALL have parameter PARITY, default 0, 0 = none, 1 = even, 2 = odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, legal 1 or 2.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_i, input, 1, reset; it is asynchronous and active-high.
REQ-007 SHALL have port baud_i, input, 1, one-clk-wide oversample tick from the external baud_generator.
REQ-008 SHALL have port data_i, input, WORD_BITS, word to send.
REQ-009 SHALL have port valid_i, input, 1, data_i is valid.
REQ-010 SHALL have port ready_o, output, 1, holding register empty; a transfer occurs on valid_i && ready_o.
REQ-011 SHALL have port tx_o, output, 1, serial line; idles high.
REQ-012 SHALL have port busy_o, output, 1, a frame is on the line.
REQ-013 SHALL have port tx_done_o, output, 1, one-clk pulse at the end of each frame.

Function
REQ-014 SHALL implement a one-entry holding register: load on transfer, clear when its word moves to the shift register.
REQ-015 SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL skip PARITY when PARITY = 0.
REQ-017 SHALL, in IDLE with holding full, go to START on the next clk edge: load the shift register, clear holding, clear the tick counter to 0, and drive tx_o = 0.
REQ-018 SHALL give each bit SAMPLE_TICKS baud_i ticks: the tick counter runs 0..SAMPLE_TICKS-1 and the bit ends on a tick while the counter = SAMPLE_TICKS-1.
REQ-019 SHALL leave all state unchanged while baud_i = 0.
REQ-020 SHALL send DATA bits LSB first, using a bit counter 0..WORD_BITS-1; the last bit ends in PARITY, or in STOP when PARITY = 0.
REQ-021 SHALL make the parity bit the XOR of the word for even parity and its inverse for odd parity, computed from the loaded word.
REQ-022 SHALL drive tx_o = 1 in STOP for STOP_BITS x SAMPLE_TICKS ticks.
REQ-023 SHALL, at the final STOP tick, pulse tx_done_o for exactly one clk cycle.
REQ-024 SHALL, at the final STOP tick, go directly to START with no idle gap if holding is full (same clk edge, same loading as REQ-017), else go to IDLE.
REQ-025 SHALL hold ready_o = 1 exactly when holding is empty, as a registered output.
REQ-026 SHALL allow a transfer in the same cycle holding empties, with the new word landing in holding.
REQ-027 SHALL hold busy_o = 1 in every state except IDLE.
REQ-028 SHALL keep data_i changes after a transfer from affecting the current or queued frame.

Reset
REQ-029 SHALL, while reset_i = 1, immediately set state = IDLE, tx_o = 1, busy_o = 0, tx_done_o = 0, ready_o = 1, holding empty, and all counters 0.
REQ-030 SHALL make reset mid-frame abort the frame, discard the holding word, and emit no tx_done_o.

Structure
REQ-031 SHALL take its parity-mode constants (NONE/EVEN/ODD) and state encodings from the shared package uart_pkg.
REQ-032 SHALL be a single module with no sub-module; the baud tick comes from the existing baud_generator, instantiated outside.

Verification
REQ-033 SHALL check defaults, data 0x55, baud_i held 1 -> tx_o = 0,1,0,1,0,1,0,1,0,1 with 16 clks per bit and one tx_done_o pulse at clk 160.
REQ-034 SHALL check PARITY = 1 with 0x07 -> parity bit 1, and PARITY = 2 with 0x07 -> parity bit 0; frame length 11 bits.
REQ-035 SHALL check 0xA5 then 0x3C offered back-to-back -> second start bit begins the clk after the first stop ends, ready_o low while holding is full, two tx_done_o pulses.
REQ-036 SHALL check WORD_BITS = 7, STOP_BITS = 2, data 0x41 -> 10-bit frame of 10 x SAMPLE_TICKS ticks, tx_o high for both stop bits.
REQ-037 SHALL check reset_i pulsed during data bit 3 -> tx_o = 1, ready_o = 1, busy_o = 0 before the next edge, no tx_done_o.
REQ-038 SHALL check baud_i held 0 for 100 clks mid-bit -> tx_o and counters frozen, then the frame resumes intact.
